// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with a synchronous flush; push and pop may
// coincide when full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues imem reads at the PC, buffers responses with their PCs
// and feeds decode. Defining FETCH_PERF_EN adds fetch/flush counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       pc_in,
  output logic                   pc_adv,
  input  logic                   redirect,
  output logic                   imem_req,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic                   imem_rvalid,
  input  logic [WIDTH-1:0]       imem_rdata,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [WIDTH-1:0]       dec_instr,
  output logic [WIDTH-1:0]       dec_pc,
  output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_flushed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  fq_state_e        state_q, state_d;
  logic [CW-1:0]    inflight_q, inflight_d, drop_q, drop_d, tag_count;
  logic [WIDTH-1:0] tag_pc, ent_pc, ent_instr;
  logic [CW:0]      credit;
  logic             redir_act, rsp_valid, rsp_drop, push, pop;

  assign redir_act = redirect && (state_q != IDLE);
  // Responses with no outstanding tag are leftovers from before a reset.
  assign rsp_valid = imem_rvalid && (tag_count != '0);
  assign rsp_drop  = rsp_valid && (redir_act || (drop_q != '0));
  assign push      = rsp_valid && !rsp_drop;
  assign pop       = dec_valid && dec_ready;
  assign credit    = {1'b0, q_count} + {1'b0, inflight_q};

  assign imem_req  = (state_q == RUN) && !redirect && (credit < DEPTH_W);
  assign pc_adv    = imem_req;
  assign imem_addr = pc_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect) state_d = FLUSH;
      FLUSH:   if (!redirect) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (imem_req && !rsp_valid)      inflight_d = inflight_q + 1'b1;
    else if (!imem_req && rsp_valid) inflight_d = inflight_q - 1'b1;

    drop_d = drop_q;
    if (redir_act)     drop_d = inflight_q - {{(CW-1){1'b0}}, rsp_valid};
    else if (rsp_drop) drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Tags are never flushed: dropped responses still retire their own tag.
  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (imem_req),
    .wdata (pc_in),
    .pop   (rsp_valid),
    .rdata (tag_pc),
    .count (tag_count)
  );

  fetch_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir_act),
    .push  (push),
    .wdata ({tag_pc, imem_rdata}),
    .pop   (pop),
    .rdata ({ent_pc, ent_instr}),
    .count (q_count)
  );

  assign dec_valid = (q_count != '0);
  assign dec_pc    = ent_pc;
  assign dec_instr = dec_valid ? ent_instr : WIDTH'(NOP_INSTR);

`ifdef FETCH_PERF_EN
  logic [31:0]   fetched_q, flushed_q;
  logic [CW-1:0] cleared;
  logic [33:0]   flushed_sum;

  // The entry popped in the redirect cycle reached decode, so it is not flushed.
  assign cleared     = redir_act ? (q_count - {{(CW-1){1'b0}}, pop}) : '0;
  assign flushed_sum = {2'b00, flushed_q} + 34'(cleared) + 34'(rsp_drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push && (fetched_q != '1)) fetched_q <= fetched_q + 1'b1;
      flushed_q <= (flushed_sum[33:32] != 2'b00) ? '1 : flushed_sum[31:0];
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule
